// File: rtl/multicycle_alu.sv
// Registered ALU: ADD/SUB/EQ/GT and their immediates finish in 1 clock; MUL is an iterative shift-add over WIDTH clocks.
// Latency: 1 cycle for single-cycle ops and illegal opcodes, WIDTH cycles for MUL. valid_out pulses once per accepted request.
// Backpressure: ready_out is low while a MUL iterates, and valid_in is ignored (not queued) during that time.
// Optional feature: define ALU_SATURATE_EN for saturating ADD/SUB/MUL results.
`timescale 1ns/1ps

module multicycle_alu #(
    parameter int WIDTH        = 8,
    parameter int OPCODE_WIDTH = 8
) (
    input  logic                    clock_in,
    input  logic                    reset_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic [OPCODE_WIDTH-1:0] opcode_in,
    input  logic [WIDTH-1:0]        alu_input1,
    input  logic [WIDTH-1:0]        alu_input2,
    output logic                    valid_out,
    output logic [WIDTH-1:0]        alu_output,
    output logic                    overflow_flag,
    output logic                    carry_flag,
    output logic                    zero_flag,
    output logic                    sign_flag,
    output logic                    parity_flag
);

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_MUL  = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_EQ   = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_GT   = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(9);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(10);

    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam int             MSB      = WIDTH - 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_ready;
    logic               r_valid;
    logic [WIDTH-1:0]   r_res;
    logic               r_ovf;
    logic               r_carry;
    logic               r_zero;
    logic               r_sign;
    logic               r_parity;

    // Multiplier datapath: multiplicand shifts left, multiplier shifts right, one bit consumed per clock.
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;

    logic [WIDTH:0]     w_add_ext;
    logic [WIDTH:0]     w_sub_ext;
    logic [WIDTH-1:0]   w_sc_res;
    logic               w_sc_ovf;
    logic               w_sc_carry;
    logic               w_sc_arith;

    logic [2*WIDTH-1:0] w_acc_nxt;
    logic               w_mul_ovf;
    logic [WIDTH-1:0]   w_mul_res;

    assign w_add_ext = {1'b0, alu_input1} + {1'b0, alu_input2};
    assign w_sub_ext = {1'b0, alu_input1} - {1'b0, alu_input2};

    // Single-cycle result and raw flags, decoded straight from the request operands.
    always_comb begin
        w_sc_res   = '0;
        w_sc_ovf   = 1'b0;
        w_sc_carry = 1'b0;
        w_sc_arith = 1'b0;
        case (opcode_in)
            OP_ADD, OP_ADDI: begin
                w_sc_res   = w_add_ext[WIDTH-1:0];
                w_sc_carry = w_add_ext[WIDTH];
                w_sc_ovf   = (alu_input1[MSB] == alu_input2[MSB]) &&
                             (w_add_ext[MSB] != alu_input1[MSB]);
                w_sc_arith = 1'b1;
            end
            OP_SUB, OP_SUBI: begin
                w_sc_res   = w_sub_ext[WIDTH-1:0];
                w_sc_carry = w_sub_ext[WIDTH];
                w_sc_ovf   = (alu_input1[MSB] != alu_input2[MSB]) &&
                             (w_sub_ext[MSB] != alu_input1[MSB]);
                w_sc_arith = 1'b1;
            end
            OP_EQ: begin
                w_sc_res = {{(WIDTH-1){1'b0}}, (alu_input1 == alu_input2)};
            end
            OP_GT: begin
                w_sc_res = {{(WIDTH-1){1'b0}}, (alu_input1 > alu_input2)};
            end
            default: begin
                w_sc_res = '0;
            end
        endcase
`ifdef ALU_SATURATE_EN
        // On signed overflow the true result has operand A's sign for both ADD and SUB.
        if (w_sc_ovf) begin
            w_sc_res = alu_input1[MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Next accumulator value; on the last step this is the full 2*WIDTH product.
    always_comb begin
        w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
        w_mul_ovf = |w_acc_nxt[2*WIDTH-1:WIDTH];
        w_mul_res = w_acc_nxt[WIDTH-1:0];
`ifdef ALU_SATURATE_EN
        if (w_mul_ovf) begin
            w_mul_res = '1;
        end
`endif
    end

    // Control FSM plus all result/flag registers; outputs change only on completion.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_state  <= ST_IDLE;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_res    <= '0;
            r_ovf    <= 1'b0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b1;
            r_sign   <= 1'b0;
            r_parity <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (valid_in) begin
                        if (opcode_in == OP_MUL) begin
                            r_state  <= ST_MUL;
                            r_ready  <= 1'b0;
                            r_mcand  <= {{WIDTH{1'b0}}, alu_input1};
                            r_mplier <= alu_input2;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                        end else begin
                            r_res    <= w_sc_res;
                            r_ovf    <= w_sc_ovf;
                            r_carry  <= w_sc_carry;
                            r_zero   <= ~|w_sc_res;
                            r_sign   <= w_sc_res[MSB];
                            r_parity <= w_sc_arith & (^w_sc_res);
                            r_valid  <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_state  <= ST_IDLE;
                        r_ready  <= 1'b1;
                        r_res    <= w_mul_res;
                        r_ovf    <= w_mul_ovf;
                        r_carry  <= w_mul_ovf;
                        r_zero   <= ~|w_mul_res;
                        r_sign   <= w_mul_res[MSB];
                        r_parity <= ^w_mul_res;
                        r_valid  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready_out     = r_ready;
    assign valid_out     = r_valid;
    assign alu_output    = r_res;
    assign overflow_flag = r_ovf;
    assign carry_flag    = r_carry;
    assign zero_flag     = r_zero;
    assign sign_flag     = r_sign;
    assign parity_flag   = r_parity;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu at WIDTH=8 against a plain-arithmetic reference model.
// Covers reset, the documented vectors, randomized ops, busy-time drops, back-to-back issue and reset during MUL.
// Honours ALU_SATURATE_EN when the same macro is defined for the build.
`timescale 1ns/1ps

module tb_multicycle_alu;

    localparam int W = 8;

    logic         clock_in  = 1'b0;
    logic         reset_in  = 1'b1;
    logic         valid_in  = 1'b0;
    logic [7:0]   opcode_in = '0;
    logic [W-1:0] alu_input1 = '0;
    logic [W-1:0] alu_input2 = '0;
    logic         ready_out;
    logic         valid_out;
    logic [W-1:0] alu_output;
    logic         overflow_flag, carry_flag, zero_flag, sign_flag, parity_flag;
    logic [12:0]  obs;

    int n_vec = 0;
    int n_err = 0;

    multicycle_alu #(.WIDTH(W), .OPCODE_WIDTH(8)) dut (
        .clock_in      (clock_in),
        .reset_in      (reset_in),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .opcode_in     (opcode_in),
        .alu_input1    (alu_input1),
        .alu_input2    (alu_input2),
        .valid_out     (valid_out),
        .alu_output    (alu_output),
        .overflow_flag (overflow_flag),
        .carry_flag    (carry_flag),
        .zero_flag     (zero_flag),
        .sign_flag     (sign_flag),
        .parity_flag   (parity_flag)
    );

    assign obs = {alu_output, overflow_flag, carry_flag, zero_flag, sign_flag, parity_flag};

    always #5 clock_in = ~clock_in;

    // Reference model: {result, ovf, carry, zero, sign, parity} from integer arithmetic.
    function automatic logic [12:0] model(input int op, input int a, input int b);
        int r, sa, sb, ss;
        bit ov, cy, arith;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        ov = 0; cy = 0; arith = 1; ss = 0;
        case (op)
            0, 9:  begin r = a + b; cy = (r > 255); ss = sa + sb; ov = (ss > 127) || (ss < -128); end
            1, 10: begin r = a - b; cy = (r < 0);   ss = sa - sb; ov = (ss > 127) || (ss < -128); end
            2:     begin r = a * b; ov = (r > 255); cy = ov; end
            3:     begin r = (a == b) ? 1 : 0; arith = 0; end
            4:     begin r = (a > b) ? 1 : 0;  arith = 0; end
            default: begin r = 0; arith = 0; end
        endcase
        r = r & 255;
`ifdef ALU_SATURATE_EN
        if (ov) r = (op == 2) ? 255 : ((ss > 127) ? 127 : 128);
`endif
        return {r[7:0], ov, cy, (r == 0), r[7], arith & (^r[7:0])};
    endfunction

    function automatic int pick_op();
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0: return 0;  1: return 1;  2: return 2;  3: return 3;  4: return 4;
            5: return 9;  6: return 10; 7: return 2;
            8: return $urandom_range(5, 8);
            default: return $urandom_range(11, 255);
        endcase
    endfunction

    function automatic int pick_operand();
        int k;
        k = $urandom_range(0, 7);
        case (k)
            0: return 8'h00; 1: return 8'h7F; 2: return 8'h80; 3: return 8'hFF;
            default: return $urandom_range(0, 255);
        endcase
    endfunction

    // Issue one request and wait (bounded) for its completion pulse.
    // lat = extra edges after the accept edge before valid_out is seen (0 for 1-cycle ops).
    task automatic run_op(input int op, input int a, input int b,
                          output int lat, output bit held, output bit busy);
        logic [W-1:0] prev;
        @(negedge clock_in);
        prev       = alu_output;
        valid_in   = 1'b1;
        opcode_in  = 8'(op);
        alu_input1 = 8'(a);
        alu_input2 = 8'(b);
        @(posedge clock_in);
        #1;
        valid_in = 1'b0;
        lat  = 0;
        held = 1;
        busy = 1;
        while (!valid_out && lat < 40) begin
            if (alu_output !== prev) held = 0;
            if (ready_out !== 1'b0) busy = 0;
            @(posedge clock_in);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        repeat (2) @(posedge clock_in);
        #1;
        n_vec++;
        if ({ready_out, valid_out, obs} !== {1'b1, 1'b0, 8'h00, 5'b00100}) begin
            n_err++;
            $display("FAIL reset_state: got rdy=%b vld=%b obs=%h, want rdy=1 vld=0 obs=%h",
                     ready_out, valid_out, obs, {8'h00, 5'b00100});
        end
        @(negedge clock_in);
        reset_in = 1'b0;
    endtask

    task automatic test_directed();
        int ops [9] = '{0, 1, 9, 2, 2, 3, 4, 8'h55, 0};
        int as  [9] = '{8'h7F, 8'h00, 8'hFF, 13, 8'h10, 8'h5A, 8'h01, 8'h12, 8'h03};
        int bs  [9] = '{8'h01, 8'h01, 8'h01, 11, 8'h10, 8'h5A, 8'h80, 8'h34, 8'h04};
        logic [12:0] want [9];
        int lat;
        bit held, busy;
`ifdef ALU_SATURATE_EN
        want[0] = {8'h7F, 5'b10001};
        want[4] = {8'hFF, 5'b11010};
`else
        want[0] = {8'h80, 5'b10011};
        want[4] = {8'h00, 5'b11100};
`endif
        want[1] = {8'hFF, 5'b01010};
        want[2] = {8'h00, 5'b01100};
        want[3] = {8'h8F, 5'b00011};
        want[5] = {8'h01, 5'b00000};
        want[6] = {8'h00, 5'b00100};
        want[7] = {8'h00, 5'b00100};
        want[8] = {8'h07, 5'b00001};
        for (int i = 0; i < 9; i++) begin
            run_op(ops[i], as[i], bs[i], lat, held, busy);
            n_vec++;
            if (obs !== want[i]) begin
                n_err++;
                $display("FAIL directed_%0d op=%0h: got %h, want %h", i, ops[i], obs, want[i]);
            end
            n_vec++;
            if (lat !== ((ops[i] == 2) ? W : 0)) begin
                n_err++;
                $display("FAIL directed_lat_%0d op=%0h: got %0d, want %0d", i, ops[i], lat,
                         (ops[i] == 2) ? W : 0);
            end
            if (ops[i] == 2) begin
                n_vec++;
                if (!held || !busy) begin
                    n_err++;
                    $display("FAIL directed_busy_%0d: got held=%b busy=%b, want 1 1", i, held, busy);
                end
            end
        end
    endtask

    task automatic test_random();
        int op, a, b, lat;
        bit held, busy;
        logic [12:0] exp_v;
        for (int i = 0; i < 150; i++) begin
            op = pick_op();
            a  = pick_operand();
            b  = pick_operand();
            exp_v = model(op, a, b);
            run_op(op, a, b, lat, held, busy);
            n_vec++;
            if (obs !== exp_v || lat !== ((op == 2) ? W : 0)) begin
                n_err++;
                $display("FAIL random_%0d op=%0h a=%h b=%h: got %h lat=%0d, want %h lat=%0d",
                         i, op, a, b, obs, lat, exp_v, (op == 2) ? W : 0);
            end
            if (op == 2) begin
                n_vec++;
                if (!held || !busy) begin
                    n_err++;
                    $display("FAIL random_hold_%0d: got held=%b busy=%b, want 1 1", i, held, busy);
                end
            end
        end
    endtask

    task automatic test_busy_ignore();
        int pulses;
        logic [12:0] seen;
        @(negedge clock_in);
        valid_in = 1'b1; opcode_in = 8'd2; alu_input1 = 8'd3; alu_input2 = 8'd5;
        @(posedge clock_in);
        #1 valid_in = 1'b0;
        repeat (2) @(posedge clock_in);
        @(negedge clock_in);
        valid_in = 1'b1; opcode_in = 8'd0; alu_input1 = 8'd1; alu_input2 = 8'd1;
        @(posedge clock_in);
        #1 valid_in = 1'b0;
        pulses = 0;
        seen = '0;
        for (int c = 0; c < 14; c++) begin
            if (valid_out) begin
                pulses++;
                seen = obs;
            end
            @(posedge clock_in);
            #1;
        end
        n_vec++;
        if (pulses !== 1 || seen !== model(2, 3, 5)) begin
            n_err++;
            $display("FAIL busy_ignore: got pulses=%0d obs=%h, want 1 %h", pulses, seen, model(2, 3, 5));
        end
    endtask

    task automatic test_back_to_back();
        int lat, op, a, b;
        bit held, busy;
        logic [12:0] exp_v;
        int b2b_ops [6] = '{0, 1, 9, 10, 3, 4};
        run_op(2, 7, 9, lat, held, busy);
        n_vec++;
        if (valid_out !== 1'b1 || ready_out !== 1'b1 || obs !== model(2, 7, 9)) begin
            n_err++;
            $display("FAIL mul_then_ready: got vld=%b rdy=%b obs=%h, want 1 1 %h",
                     valid_out, ready_out, obs, model(2, 7, 9));
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clock_in);
            op = b2b_ops[k];
            a  = pick_operand();
            b  = pick_operand();
            valid_in = 1'b1; opcode_in = 8'(op); alu_input1 = 8'(a); alu_input2 = 8'(b);
            exp_v = model(op, a, b);
            @(posedge clock_in);
            #1;
            n_vec++;
            if (valid_out !== 1'b1 || obs !== exp_v) begin
                n_err++;
                $display("FAIL back_to_back_%0d op=%0h: got vld=%b obs=%h, want 1 %h",
                         k, op, valid_out, obs, exp_v);
            end
        end
        @(negedge clock_in);
        valid_in = 1'b0;
        @(posedge clock_in);
        #1;
        n_vec++;
        if (valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL back_to_back_idle: got vld=%b, want 0", valid_out);
        end
    endtask

    task automatic test_reset_mid_mul();
        int pulses, lat;
        bit held, busy;
        @(negedge clock_in);
        valid_in = 1'b1; opcode_in = 8'd2; alu_input1 = 8'hFF; alu_input2 = 8'hFF;
        @(posedge clock_in);
        #1 valid_in = 1'b0;
        repeat (3) @(posedge clock_in);
        @(negedge clock_in);
        reset_in = 1'b1;
        #1;
        n_vec++;
        if ({ready_out, valid_out, obs} !== {1'b1, 1'b0, 8'h00, 5'b00100}) begin
            n_err++;
            $display("FAIL reset_mid_mul: got rdy=%b vld=%b obs=%h, want 1 0 %h",
                     ready_out, valid_out, obs, {8'h00, 5'b00100});
        end
        @(negedge clock_in);
        reset_in = 1'b0;
        pulses = 0;
        for (int c = 0; c < W + 4; c++) begin
            @(posedge clock_in);
            #1;
            if (valid_out) pulses++;
        end
        n_vec++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL reset_abort: got %0d valid_out pulses, want 0", pulses);
        end
        run_op(2, 6, 7, lat, held, busy);
        n_vec++;
        if (obs !== model(2, 6, 7) || lat !== W) begin
            n_err++;
            $display("FAIL after_reset_mul: got %h lat=%0d, want %h lat=%0d", obs, lat, model(2, 6, 7), W);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_mul();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
